// File: rtl/l2_arbiter_pkg.sv
// Shared cache/arbiter types for the L2 arbiter slice (package cache_types).
// Holds the LC-3b word/line types and the arbiter state and source encodings.
package cache_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_src_t;

  localparam lc3b_mem_wmask FULL_WMASK = 2'b11;

endpackage

// File: rtl/l2_arbiter_select.sv
// Combinational tie-break for the L2 arbiter: picks which cache gets the next grant.
// On a tie the source that was not granted last wins.
module arb_select
  import cache_types::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_src_t last_grant,
  output arb_src_t grant
);

  // Lone requester wins; a tie goes to whichever side was not served last
  always_comb begin
    grant = ICACHE;
    if (i_req && d_req) begin
      grant = (last_grant == ICACHE) ? DCACHE : ICACHE;
    end else if (d_req) begin
      grant = DCACHE;
    end else begin
      grant = ICACHE;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto a single L2 port, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN alternates grants on ties; otherwise the D-cache always wins.
module l2_arbiter
  import cache_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  lc3b_word      icache_address,
  input  logic          icache_read,
  output cache_line     icache_rdata,
  output logic          icache_resp,
  input  lc3b_word      dcache_address,
  input  cache_line     dcache_wdata,
  input  logic          dcache_read,
  input  logic          dcache_write,
  output cache_line     dcache_rdata,
  output logic          dcache_resp,
  output lc3b_word      l2_address,
  output cache_line     l2_wdata,
  output logic          l2_read,
  output logic          l2_write,
  output lc3b_mem_wmask l2_byte_enable,
  input  cache_line     l2_rdata,
  input  logic          l2_resp
);

  arb_state_t state_q, state_d;
  lc3b_word   addr_q, addr_d;
  cache_line  wdata_q, wdata_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       i_req_s, d_req_s;
  arb_src_t   grant_s, last_grant_s;

  assign i_req_s = icache_read;
  assign d_req_s = dcache_read | dcache_write;

`ifdef ARB_ROUND_ROBIN_EN
  arb_src_t last_grant_q, last_grant_d;

  // Remember who was granted so the next tie goes the other way
  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) && (i_req_s || d_req_s)) begin
      last_grant_d = grant_s;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= ICACHE;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_s = last_grant_q;
`else
  // Pretending the I-cache was served last makes every tie go to the D-cache
  assign last_grant_s = ICACHE;
`endif

  arb_select u_arb_select (
    .i_req      (i_req_s),
    .d_req      (d_req_s),
    .last_grant (last_grant_s),
    .grant      (grant_s)
  );

  // Next-state logic: grant from IDLE, hold the request until the L2 responds
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (i_req_s || d_req_s) begin
          if (grant_s == DCACHE) begin
            state_d = SERVE_D;
            addr_d  = dcache_address;
            wdata_d = dcache_wdata;
            wr_d    = dcache_write;
            rd_d    = ~dcache_write;
          end else begin
            state_d = SERVE_I;
            addr_d  = icache_address;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 128'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign l2_address     = addr_q;
  assign l2_wdata       = wdata_q;
  assign l2_read        = rd_q;
  assign l2_write       = wr_q;
  assign l2_byte_enable = FULL_WMASK;

  // Read data passes straight through; only the resp strobes qualify it
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;
  assign icache_resp  = (state_q == SERVE_I) & l2_resp;
  assign dcache_resp  = (state_q == SERVE_D) & l2_resp;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: a grant-order model predicts L2 transactions, a monitor checks them.
// Honours ARB_ROUND_ROBIN_EN when the same macro is defined for the bench.
module tb_l2_arbiter;
  import cache_types::*;

  logic          clk = 1'b0;
  logic          rst_n;
  lc3b_word      icache_address;
  logic          icache_read;
  cache_line     icache_rdata;
  logic          icache_resp;
  lc3b_word      dcache_address;
  cache_line     dcache_wdata;
  logic          dcache_read;
  logic          dcache_write;
  cache_line     dcache_rdata;
  logic          dcache_resp;
  lc3b_word      l2_address;
  cache_line     l2_wdata;
  logic          l2_read;
  logic          l2_write;
  lc3b_mem_wmask l2_byte_enable;
  cache_line     l2_rdata;
  logic          l2_resp;

  always #5 clk = ~clk;

  l2_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_address (icache_address),
    .icache_read    (icache_read),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_address (dcache_address),
    .dcache_wdata   (dcache_wdata),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .l2_address     (l2_address),
    .l2_wdata       (l2_wdata),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_byte_enable (l2_byte_enable),
    .l2_rdata       (l2_rdata),
    .l2_resp        (l2_resp)
  );

  typedef struct {
    logic      src_d;
    lc3b_word  addr;
    logic      wr;
    cache_line wdata;
    int        lat;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;
  logic resp_en = 1'b0;
  logic spur_resp = 1'b0;
  int   fixed_lat = -1;
  logic model_last_d = 1'b0;

  function automatic cache_line gen_line(lc3b_word a);
    return {8{a, a ^ 16'hA5A5}};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // L2 model: answers each transaction after 0..3 extra cycles with address-derived data
  initial begin
    int   lat;
    logic busy;
    lat = 0;
    busy = 1'b0;
    l2_resp = 1'b0;
    l2_rdata = 128'h0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        l2_resp = 1'b0;
        l2_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (l2_read || l2_write) begin
          if (!busy) begin
            busy = 1'b1;
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          end
          if (lat == 0) begin
            l2_resp = 1'b1;
            l2_rdata = gen_line(l2_address);
            busy = 1'b0;
          end else begin
            lat--;
          end
        end
      end else begin
        busy = 1'b0;
        l2_resp = spur_resp;
        l2_rdata = gen_line(16'h0BAD);
      end
    end
  end

  // Monitor: pops the expected transaction when the L2 port starts and checks it through to resp
  initial begin
    txn_t cur;
    int   cnt;
    logic in_txn;
    in_txn = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_txn = 1'b0;
      end else begin
        if (!in_txn && (l2_read || l2_write)) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_l2_txn actual addr=%h required=no transaction", l2_address);
            cur.src_d = dcache_resp;
            cur.addr = l2_address;
            cur.wr = l2_write;
            cur.wdata = l2_wdata;
            cur.lat = -1;
          end else begin
            cur = exp_q.pop_front();
            check("l2_address", l2_address, cur.addr);
            check("l2_rd_wr", {l2_read, l2_write}, cur.wr ? 2'b01 : 2'b10);
            check("l2_byte_enable", l2_byte_enable, 2'b11);
            if (cur.wr) check("l2_wdata", l2_wdata, cur.wdata);
            check("rdata_passthru", {icache_rdata ^ l2_rdata, dcache_rdata ^ l2_rdata}, 256'h0);
          end
          in_txn = 1'b1;
          cnt = 1;
        end else if (in_txn) begin
          cnt++;
        end
        if (in_txn) begin
          if (icache_resp || dcache_resp) begin
            check("resp_src", {icache_resp, dcache_resp}, cur.src_d ? 2'b01 : 2'b10);
            check("resp_rdata", cur.src_d ? dcache_rdata : icache_rdata, gen_line(cur.addr));
            if (cur.lat >= 0) check("txn_cycles", cnt, cur.lat + 1);
            in_txn = 1'b0;
          end else if (!(l2_read || l2_write)) begin
            checks++;
            failures++;
            $display("FAIL l2_req_dropped actual=0 required=1 addr=%h", cur.addr);
            in_txn = 1'b0;
          end else begin
            check("l2_addr_stable", l2_address, cur.addr);
          end
        end else if (icache_resp || dcache_resp) begin
          check("spurious_resp", {icache_resp, dcache_resp}, 2'b00);
        end
      end
    end
  end

  function automatic txn_t mk(logic src_d, lc3b_word a, logic wr, cache_line w);
    txn_t t;
    t.src_d = src_d;
    t.addr = a;
    t.wr = wr;
    t.wdata = w;
    t.lat = fixed_lat;
    return t;
  endfunction

  // kind: 0 I only, 1 D only, 2 both together, 3 D then I one cycle later
  task automatic run_round(int kind, lc3b_word ia, lc3b_word da, cache_line dw, logic drd, logic dwr);
    txn_t ti, td;
    logic d_first, i_pending, i_seen, d_seen, done;
    ti = mk(1'b0, ia, 1'b0, 128'h0);
    td = mk(1'b1, da, dwr, dw);
    case (kind)
      0: begin exp_q.push_back(ti); model_last_d = 1'b0; end
      1: begin exp_q.push_back(td); model_last_d = 1'b1; end
      2: begin
`ifdef ARB_ROUND_ROBIN_EN
        d_first = !model_last_d;
`else
        d_first = 1'b1;
`endif
        if (d_first) begin
          exp_q.push_back(td); exp_q.push_back(ti); model_last_d = 1'b0;
        end else begin
          exp_q.push_back(ti); exp_q.push_back(td); model_last_d = 1'b1;
        end
      end
      default: begin exp_q.push_back(td); exp_q.push_back(ti); model_last_d = 1'b0; end
    endcase
    @(posedge clk);
    #1;
    icache_address = ia;
    dcache_address = da;
    dcache_wdata = dw;
    if (kind != 1 && kind != 3) icache_read = 1'b1;
    if (kind != 0) begin dcache_read = drd; dcache_write = dwr; end
    i_pending = (kind == 3);
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!icache_read && !dcache_read && !dcache_write && !i_pending) begin
        done = 1'b1;
        break;
      end
      i_seen = icache_read & icache_resp;
      d_seen = (dcache_read | dcache_write) & dcache_resp;
      @(posedge clk);
      #1;
      if (i_seen) icache_read = 1'b0;
      if (d_seen) begin dcache_read = 1'b0; dcache_write = 1'b0; end
      if (i_pending) begin icache_read = 1'b1; i_pending = 1'b0; end
      icache_address = icache_read ? ia : lc3b_word'($urandom);
      dcache_address = (dcache_read | dcache_write) ? da : lc3b_word'($urandom);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL round_timeout actual=requests pending required=all served kind=%0d", kind);
      icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
    end
  endtask

  initial begin
    int kind;
    logic drd, dwr;
    rst_n = 1'b0;
    icache_address = 16'h0; icache_read = 1'b0;
    dcache_address = 16'h0; dcache_wdata = 128'h0; dcache_read = 1'b0; dcache_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_l2_rd_wr", {l2_read, l2_write}, 2'b00);
    check("rst_l2_address", l2_address, 16'h0000);
    check("rst_l2_wdata", l2_wdata, 128'h0);
    check("rst_resp", {icache_resp, dcache_resp}, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_en = 1'b1;
    mon_en = 1'b1;

    fixed_lat = 3;
    run_round(0, 16'h1230, 16'h0000, 128'h0, 1'b0, 1'b0);
    fixed_lat = 1;
    run_round(1, 16'h0000, 16'h4000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 1'b1);
    run_round(1, 16'h0000, 16'h4010, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 1'b1, 1'b1);
    fixed_lat = 0;
    for (int r = 0; r < 3; r++) run_round(2, 16'h2000 + 16'(r), 16'h6000 + 16'(r), 128'h0, 1'b1, 1'b0);
    fixed_lat = 2;
    run_round(3, 16'h3456, 16'h789A, 128'h0, 1'b1, 1'b0);
    fixed_lat = -1;
    for (int r = 0; r < 40; r++) begin
      kind = int'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: begin drd = 1'b1; dwr = 1'b0; end
        1: begin drd = 1'b0; dwr = 1'b1; end
        default: begin drd = 1'b1; dwr = 1'b1; end
      endcase
      run_round(kind, lc3b_word'($urandom), lc3b_word'($urandom),
                {$urandom, $urandom, $urandom, $urandom}, drd, dwr);
    end
    check("sb_drained", exp_q.size(), 0);

    // Reset in the middle of an I-cache transaction, then a stray L2 resp
    mon_en = 1'b0;
    resp_en = 1'b0;
    spur_resp = 1'b0;
    @(posedge clk);
    #1;
    icache_address = 16'h2222;
    icache_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_pre_l2_read", l2_read, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    icache_read = 1'b0;
    spur_resp = 1'b1;
    @(negedge clk);
    check("mid_rst_l2_read", {l2_read, l2_write}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("spur_resp_ignored", {icache_resp, dcache_resp}, 2'b00);
    check("mid_rst_l2_address", l2_address, 16'h0000);
    @(posedge clk);
    #1;
    spur_resp = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {l2_read, l2_write}, 2'b00);

    model_last_d = 1'b0;
    mon_en = 1'b1;
    resp_en = 1'b1;
    run_round(2, 16'h0A0A, 16'h0B0B, 128'h0, 1'b1, 1'b0);
    run_round(2, 16'h0C0C, 16'h0D0D, 128'hFFFF, 1'b0, 1'b1);
    check("sb_drained_final", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: icache_address  input  16 (lc3b_word); icache_read  input  1; icache_rdata  output  cache_line; icache_resp  output  1.
REQ-004 SHALL have ports: dcache_address  input  16; dcache_wdata  input  cache_line; dcache_read  input  1; dcache_write  input  1; dcache_rdata  output  cache_line; dcache_resp  output  1.
REQ-005 SHALL have ports: l2_address  output  16; l2_wdata  output  cache_line; l2_read  output  1; l2_write  output  1; l2_byte_enable  output  2 (lc3b_mem_wmask, constant 2'b11); l2_rdata  input  cache_line; l2_resp  input  1.

Function
REQ-006 SHALL arbitrate line requests from I-cache and D-cache onto one L2 port; one outstanding L2 transaction at a time.
REQ-007 SHALL implement FSM states IDLE, SERVE_I, SERVE_D.
REQ-008 IDLE: no request -> stay; only I -> SERVE_I; only D -> SERVE_D; both -> per REQ-015.
REQ-009 On grant, SHALL latch requester address, D-cache wdata and read/write type into registers; L2 outputs driven only from these registers.
REQ-010 l2_read/l2_write SHALL assert the cycle after the grant cycle and hold until l2_resp is sampled high.
REQ-011 On l2_resp in SERVE_x, SHALL pulse x_resp combinationally in that same cycle, return to IDLE next cycle, and drop l2_read/l2_write.
REQ-012 icache_rdata and dcache_rdata SHALL equal l2_rdata continuously; resp gating alone marks validity.
REQ-013 l2_resp in IDLE SHALL be ignored; the non-granted requester SHALL see resp=0 for the whole transaction.
REQ-014 dcache_read and dcache_write both high SHALL be treated as a write.
REQ-015 Tie with ARB_ROUND_ROBIN_EN undefined: D-cache wins always.
REQ-016 Request held across the grant cycle SHALL NOT be re-granted twice: IDLE entered after resp sees requester deasserted (requesters drop request the cycle after resp).
REQ-017 Minimum request-to-resp latency SHALL be 2 cycles (grant, then L2 one-cycle hit).

Reset
REQ-018 With rst_n low at a clock edge: state=IDLE, l2_read=0, l2_write=0, latched address/wdata=0, icache_resp=0, dcache_resp=0, last_grant=ICACHE.
REQ-019 Reset mid-transaction SHALL abandon it; no resp issued; a later l2_resp SHALL be ignored.

Configuration
REQ-020 Macro ARB_ROUND_ROBIN_EN: defined -> on tie, grant the source not in last_grant; last_grant updates at each grant; first tie after reset goes to D-cache.
REQ-021 Macro undefined -> fixed D-cache priority; last_grant register SHALL not be synthesised.

Structure
REQ-022 Types arb_state_t (IDLE, SERVE_I, SERVE_D) and arb_src_t (ICACHE, DCACHE) SHALL live in package cache_types; existing cache_line, lc3b_word, lc3b_mem_wmask SHALL be reused.
REQ-023 Tie-break logic SHALL be one combinational sub-module arb_select (inputs: i_req, d_req, last_grant; output: grant source).

Verification
REQ-024 I read only, addr 0x1230, L2 resp after 3 cycles with data D0 -> l2_read high cycles 1-4, l2_address 0x1230, icache_resp one cycle with icache_rdata=D0.
REQ-025 D write addr 0x4000, wdata W1 -> l2_write high, l2_wdata=W1, l2_byte_enable=2'b11, dcache_resp on l2_resp, icache_resp stays 0.
REQ-026 I and D read together, repeated 3 times -> without macro D,I,D...; with ARB_ROUND_ROBIN_EN grants D,I,D,I alternate.
REQ-027 I request arrives during SERVE_D -> I granted only after D resp, in next IDLE cycle; I address stable on L2 while D active not altered.
REQ-028 rst_n low during SERVE_I before l2_resp, then spurious l2_resp -> no icache_resp, l2_read=0, state IDLE.
REQ-029 dcache_read and dcache_write both high -> l2_write=1, l2_read=0.
